// File: rtl/approx_eight_bit_sequential_divider.sv
// -----------------------------------------------------------------------------
// approx_eight_bit_sequential_divider
//
// Purpose:
//   Iterative restoring divider: a 16-bit unsigned dividend divided by an
//   8-bit unsigned divisor. It yields an 8-bit quotient and an 8-bit remainder.
//   The divider resolves one quotient bit per clock, so a division takes
//   8 iterations after the request is accepted.
//
//   Two cases are resolved in IDLE in the same cycle that start is sampled:
//     - Divide-by-zero: the divisor is zero.
//     - Quotient overflow: dividend[15:8] >= divisor, so the quotient does
//       not fit in 8 bits.
//
// Configuration macro:
//   APPROX_SUB_EN
//     Defined:   bits 0 and 1 of the 9-bit trial subtractor ignore borrow-in
//                in their borrow-out. This mirrors the approximate adder
//                cells of the companion multiplier.
//     Undefined: the subtractor is exact ripple-borrow, so the division is
//                bit-exact.
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst        in   1   asynchronous active-high reset
//   start      in   1   request; sampled only while idle
//   dividend   in  16   unsigned dividend, sampled with start
//   divisor    in   8   unsigned divisor, sampled with start
//   busy       out  1   high while a division is iterating
//   done       out  1   one-cycle completion pulse
//   quotient   out  8   registered quotient
//   remainder  out  8   registered remainder
//   err        out  1   registered divide-by-zero / overflow flag
// -----------------------------------------------------------------------------
module approx_eight_bit_sequential_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        busy,
    output logic        done,
    output logic [7:0]  quotient,
    output logic [7:0]  remainder,
    output logic        err
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_CALC = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [8:0]  r_rem;
    logic [7:0]  r_quo;
    logic [7:0]  r_div;
    logic [2:0]  r_count;

    logic        w_div_zero;
    logic        w_overflow;
    logic        w_accept;
    logic        w_last_iter;

    logic [8:0]  w_trial;
    logic [8:0]  w_sub_b;
    logic [8:0]  w_diff;
    logic [8:0]  w_bin;
    logic [8:0]  w_bout;
    logic        w_no_borrow;
    logic [8:0]  w_rem_next;
    logic [7:0]  w_quo_next;

    assign w_div_zero  = (divisor == 8'd0);
    assign w_overflow  = (dividend[15:8] >= divisor);
    assign w_accept    = start && !w_div_zero && !w_overflow;
    assign w_last_iter = (r_count == 3'd7);

    // Shift the next dividend bit into the partial remainder, then try to subtract.
    assign w_trial = {r_rem[7:0], r_quo[7]};
    assign w_sub_b = {1'b0, r_div};
    assign w_bin   = {w_bout[7:0], 1'b0};

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_sub
            assign w_diff[gi] = w_trial[gi] ^ w_sub_b[gi] ^ w_bin[gi];
`ifdef APPROX_SUB_EN
            if (gi < 2) begin : g_approx
                // The borrow-in only affects the difference bit here, never the chain.
                assign w_bout[gi] = ~w_trial[gi] & w_sub_b[gi];
            end else begin : g_exact
                assign w_bout[gi] = (~w_trial[gi] & w_sub_b[gi])
                                  | (~(w_trial[gi] ^ w_sub_b[gi]) & w_bin[gi]);
            end
`else
            assign w_bout[gi] = (~w_trial[gi] & w_sub_b[gi])
                              | (~(w_trial[gi] ^ w_sub_b[gi]) & w_bin[gi]);
`endif
        end
    endgenerate

    // No final borrow means trial >= divisor: keep the difference and emit a 1.
    assign w_no_borrow = ~w_bout[8];
    assign w_rem_next  = w_no_borrow ? w_diff : w_trial;
    assign w_quo_next  = {r_quo[6:0], w_no_borrow};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)    w_state_next = S_CALC;
            S_CALC:  if (w_last_iter) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_rem     <= 9'd0;
            r_quo     <= 8'd0;
            r_div     <= 8'd0;
            r_count   <= 3'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= 8'd0;
            remainder <= 8'd0;
            err       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            done    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_div_zero) begin
                            quotient  <= 8'hFF;
                            remainder <= dividend[7:0];
                            err       <= 1'b1;
                            done      <= 1'b1;
                        end else if (w_overflow) begin
                            quotient  <= 8'hFF;
                            remainder <= 8'hFF;
                            err       <= 1'b1;
                            done      <= 1'b1;
                        end else begin
                            r_rem   <= {1'b0, dividend[15:8]};
                            r_quo   <= dividend[7:0];
                            r_div   <= divisor;
                            r_count <= 3'd0;
                            err     <= 1'b0;
                            busy    <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    r_rem   <= w_rem_next;
                    r_quo   <= w_quo_next;
                    r_count <= r_count + 3'd1;
                    if (w_last_iter) begin
                        quotient  <= w_quo_next;
                        remainder <= w_rem_next[7:0];
                        done      <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_approx_eight_bit_sequential_divider.sv
module tb_approx_eight_bit_sequential_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    approx_eight_bit_sequential_divider dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Waits for done after acceptance; returns edges waited and busy-high samples.
    task automatic wait_done(output int lat, output int nbusy);
        lat   = 0;
        nbusy = 1;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (!done && busy) nbusy++;
        end
    endtask

    task automatic run_op(input logic [15:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er, input logic ee);
        int lat;
        int nbusy;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (ee) begin
            check_val("err_done", done, 1'b1);
            check_val("err_busy", busy, 1'b0);
        end else begin
            check_val("busy_after_accept", busy, 1'b1);
            wait_done(lat, nbusy);
            check_val("latency", lat, 16'd8);
            check_val("busy_cycles", nbusy, 16'd8);
        end
        check_val("quotient", quotient, eq);
        check_val("remainder", remainder, er);
        check_val("err", err, ee);
        check_val("busy_at_done", busy, 1'b0);
        $display("[TB] %0d / %0d -> q=%0d r=%0d err=%0d", a, b, quotient, remainder, err);
        @(posedge clk); #1;
        check_val("done_single", done, 1'b0);
        check_val("busy_after", busy, 1'b0);
    endtask

    initial begin
        int lat;
        int nbusy;
        bit saw_done;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = 16'd0;
        divisor  = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_done", done, 1'b0);
        check_val("rst_q", quotient, 8'd0);
        check_val("rst_r", remainder, 8'd0);
        check_val("rst_err", err, 1'b0);
        $display("[TB] reset released");
        @(negedge clk);
        rst = 1'b0;

        run_op(16'd1000, 8'd10,  8'd100,  8'd0,   1'b0);
        run_op(16'h7F00, 8'h80,  8'hFE,   8'h00,  1'b0);
        run_op(16'h1234, 8'h00,  8'hFF,   8'h34,  1'b1);
        run_op(16'hFEFF, 8'hFF,  8'hFF,   8'hFE,  1'b0);
        run_op(16'h0500, 8'h05,  8'hFF,   8'hFF,  1'b1);
        run_op(16'h00FF, 8'hFF,  8'h01,   8'h00,  1'b0);
        run_op(16'h0100, 8'h01,  8'hFF,   8'hFF,  1'b1);
        run_op(16'h0000, 8'h00,  8'hFF,   8'h00,  1'b1);
        run_op(16'd255,  8'd16,  8'd15,   8'd15,  1'b0);

        // start held high through CALC with new operands: ignored until IDLE.
        @(negedge clk);
        dividend = 16'd1000;
        divisor  = 8'd10;
        start    = 1'b1;
        @(posedge clk); #1;
        dividend = 16'd7;
        divisor  = 8'd2;
        wait_done(lat, nbusy);
        check_val("held_latency1", lat, 16'd8);
        check_val("held_q1", quotient, 8'd100);
        check_val("held_r1", remainder, 8'd0);
        $display("[TB] held-start first: q=%0d r=%0d", quotient, remainder);
        @(posedge clk); #1;
        start = 1'b0;
        check_val("held_accept2", busy, 1'b1);
        wait_done(lat, nbusy);
        check_val("held_latency2", lat, 16'd8);
        check_val("held_q2", quotient, 8'd3);
        check_val("held_r2", remainder, 8'd1);
        $display("[TB] held-start second: q=%0d r=%0d", quotient, remainder);
        @(posedge clk); #1;

        // Abort in the 4th CALC cycle.
        @(negedge clk);
        dividend = 16'd1000;
        divisor  = 8'd10;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_val("abort_busy", busy, 1'b0);
        check_val("abort_done", done, 1'b0);
        check_val("abort_q", quotient, 8'd0);
        check_val("abort_r", remainder, 8'd0);
        check_val("abort_err", err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        check_val("abort_no_done", saw_done, 1'b0);
        $display("[TB] abort during CALC checked");
        run_op(16'd255, 8'd16, 8'd15, 8'd15, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
